riscv_decode: RTL and testbench

//  Decode stage of the single-cycle-issue RISC-V (RV32I) core, directly downstream of instruction fetch.

---
 rtl/riscv_pkg.sv | 69 ++++++
 rtl/riscv_regfile.sv | 40 ++++
 rtl/riscv_decode.sv | 144 ++++++++++++++
 tb/tb_riscv_decode.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I decode types: opcodes, ALU operations, control-bit indices, immediate formats.
package riscv_pkg;

   localparam int XLEN     = 32;
   localparam int NUM_REGS = 32;
   localparam int REG_AW   = $clog2(NUM_REGS);

   typedef logic [6:0] opcode_t;

   localparam opcode_t OPC_LUI    = 7'b0110111;
   localparam opcode_t OPC_AUIPC  = 7'b0010111;
   localparam opcode_t OPC_JAL    = 7'b1101111;
   localparam opcode_t OPC_JALR   = 7'b1100111;
   localparam opcode_t OPC_BRANCH = 7'b1100011;
   localparam opcode_t OPC_LOAD   = 7'b0000011;
   localparam opcode_t OPC_STORE  = 7'b0100011;
   localparam opcode_t OPC_OP_IMM = 7'b0010011;
   localparam opcode_t OPC_OP     = 7'b0110011;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SLL  = 4'b0001,
      ALU_SLT  = 4'b0010,
      ALU_SLTU = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_SRL  = 4'b0101,
      ALU_OR   = 4'b0110,
      ALU_AND  = 4'b0111,
      ALU_SUB  = 4'b1000,
      ALU_SRA  = 4'b1101
   } alu_op_t;

   localparam int CTRL_W       = 9;
   localparam int CTRL_RF_WE   = 8;
   localparam int CTRL_ALU_IMM = 7;
   localparam int CTRL_LOAD    = 6;
   localparam int CTRL_STORE   = 5;
   localparam int CTRL_BRANCH  = 4;
   localparam int CTRL_JAL     = 3;
   localparam int CTRL_JALR    = 2;
   localparam int CTRL_LUI     = 1;
   localparam int CTRL_AUIPC   = 0;

   typedef enum logic [2:0] {
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J
   } imm_fmt_t;

   function automatic logic [XLEN-1:0] gen_imm(
      input imm_fmt_t        fmt,
      input logic [XLEN-1:0] ins
   );
      logic [XLEN-1:0] imm;
      unique case (fmt)
         IMM_S:   imm = {{21{ins[31]}}, ins[30:25], ins[11:7]};
         IMM_B:   imm = {{20{ins[31]}}, ins[7], ins[30:25],
                         ins[11:8], 1'b0};
         IMM_U:   imm = {ins[31:12], 12'b0};
         IMM_J:   imm = {{12{ins[31]}}, ins[19:12], ins[20],
                         ins[30:21], 1'b0};
         default: imm = {{21{ins[31]}}, ins[30:20]};
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/riscv_regfile.sv
// Integer register file: 2 async reads, 1 sync write, x0 hardwired to zero.
// Optional same-cycle write-to-read forwarding when RISCV_RF_BYPASS_EN is defined.
module riscv_regfile
   import riscv_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] rs1_addr,
   input  logic [REG_AW-1:0] rs2_addr,
   output logic [XLEN-1:0]   rs1_data,
   output logic [XLEN-1:0]   rs2_data,
   input  logic              we,
   input  logic [REG_AW-1:0] wr_addr,
   input  logic [XLEN-1:0]   wr_data
);

   logic [XLEN-1:0] regs [1:NUM_REGS-1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (we && wr_addr != '0) begin
         regs[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      rs1_data = '0;
      rs2_data = '0;
      if (rs1_addr != '0) rs1_data = regs[rs1_addr];
      if (rs2_addr != '0) rs2_data = regs[rs2_addr];
`ifdef RISCV_RF_BYPASS_EN
      if (we && rs1_addr != '0 && wr_addr == rs1_addr)
         rs1_data = wr_data;
      if (we && rs2_addr != '0 && wr_addr == rs2_addr)
         rs2_data = wr_data;
`endif
   end

endmodule

// File: rtl/riscv_decode.sv
// RV32I decode stage: combinational decode/immediate gen feeding a capture register.
// Register-file write-back bypass is enabled by defining RISCV_RF_BYPASS_EN.
module riscv_decode
   import riscv_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              if_dec_valid_i,
   input  logic [XLEN-1:0]   if_dec_instr_i,
   input  logic              wb_rf_we_i,
   input  logic [REG_AW-1:0] wb_rd_addr_i,
   input  logic [XLEN-1:0]   wb_rd_data_i,
   output logic              dec_ex_valid_o,
   output logic [XLEN-1:0]   dec_ex_rs1_data_o,
   output logic [XLEN-1:0]   dec_ex_rs2_data_o,
   output logic [XLEN-1:0]   dec_ex_imm_o,
   output logic [REG_AW-1:0] dec_ex_rd_addr_o,
   output logic [2:0]        dec_ex_funct3_o,
   output logic [3:0]        dec_ex_alu_op_o,
   output logic [CTRL_W-1:0] dec_ex_ctrl_o,
   output logic              dec_ex_illegal_o
);

   opcode_t           opc;
   logic [2:0]        f3;
   logic [6:0]        f7;
   logic [REG_AW-1:0] rd;
   logic [XLEN-1:0]   rs1_data;
   logic [XLEN-1:0]   rs2_data;
   logic [CTRL_W-1:0] ctrl;
   logic [3:0]        alu_op;
   logic              illegal;
   imm_fmt_t          fmt;

   assign opc = if_dec_instr_i[6:0];
   assign rd  = if_dec_instr_i[11:7];
   assign f3  = if_dec_instr_i[14:12];
   assign f7  = if_dec_instr_i[31:25];

   riscv_regfile u_rf (
      .clk      (clk),
      .reset    (reset),
      .rs1_addr (if_dec_instr_i[19:15]),
      .rs2_addr (if_dec_instr_i[24:20]),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .we       (wb_rf_we_i),
      .wr_addr  (wb_rd_addr_i),
      .wr_data  (wb_rd_data_i)
   );

   always_comb begin
      ctrl    = '0;
      alu_op  = ALU_ADD;
      illegal = 1'b0;
      fmt     = IMM_I;
      unique case (opc)
         OPC_LUI: begin
            ctrl[CTRL_LUI]     = 1'b1;
            ctrl[CTRL_RF_WE]   = 1'b1;
            ctrl[CTRL_ALU_IMM] = 1'b1;
            fmt = IMM_U;
         end
         OPC_AUIPC: begin
            ctrl[CTRL_AUIPC]   = 1'b1;
            ctrl[CTRL_RF_WE]   = 1'b1;
            ctrl[CTRL_ALU_IMM] = 1'b1;
            fmt = IMM_U;
         end
         OPC_JAL: begin
            ctrl[CTRL_JAL]   = 1'b1;
            ctrl[CTRL_RF_WE] = 1'b1;
            fmt = IMM_J;
         end
         OPC_JALR: begin
            ctrl[CTRL_JALR]    = 1'b1;
            ctrl[CTRL_RF_WE]   = 1'b1;
            ctrl[CTRL_ALU_IMM] = 1'b1;
         end
         OPC_BRANCH: begin
            ctrl[CTRL_BRANCH] = 1'b1;
            alu_op  = ALU_SUB;
            fmt     = IMM_B;
            illegal = (f3 == 3'b010) || (f3 == 3'b011);
         end
         OPC_LOAD: begin
            ctrl[CTRL_LOAD]    = 1'b1;
            ctrl[CTRL_RF_WE]   = 1'b1;
            ctrl[CTRL_ALU_IMM] = 1'b1;
            illegal = (f3 == 3'b011) || (f3[2:1] == 2'b11);
         end
         OPC_STORE: begin
            ctrl[CTRL_STORE]   = 1'b1;
            ctrl[CTRL_ALU_IMM] = 1'b1;
            fmt     = IMM_S;
            illegal = (f3 > 3'b010);
         end
         OPC_OP_IMM: begin
            ctrl[CTRL_RF_WE]   = 1'b1;
            ctrl[CTRL_ALU_IMM] = 1'b1;
            alu_op = {(f3 == 3'b101) & f7[5], f3};
         end
         OPC_OP: begin
            ctrl[CTRL_RF_WE] = 1'b1;
            alu_op  = {f7[5], f3};
            illegal = (f7 != 7'b0000000) && (f7 != 7'b0100000);
         end
         default: illegal = 1'b1;
      endcase
      // rd == x0 never commits, so suppress the write enable here
      if (rd == '0) ctrl[CTRL_RF_WE] = 1'b0;
      if (illegal) begin
         ctrl   = '0;
         alu_op = ALU_ADD;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dec_ex_valid_o    <= 1'b0;
         dec_ex_rs1_data_o <= '0;
         dec_ex_rs2_data_o <= '0;
         dec_ex_imm_o      <= '0;
         dec_ex_rd_addr_o  <= '0;
         dec_ex_funct3_o   <= '0;
         dec_ex_alu_op_o   <= '0;
         dec_ex_ctrl_o     <= '0;
         dec_ex_illegal_o  <= 1'b0;
      end else begin
         dec_ex_valid_o <= if_dec_valid_i;
         if (if_dec_valid_i) begin
            dec_ex_rs1_data_o <= rs1_data;
            dec_ex_rs2_data_o <= rs2_data;
            dec_ex_imm_o      <= gen_imm(fmt, if_dec_instr_i);
            dec_ex_rd_addr_o  <= rd;
            dec_ex_funct3_o   <= f3;
            dec_ex_alu_op_o   <= alu_op;
            dec_ex_ctrl_o     <= ctrl;
            dec_ex_illegal_o  <= illegal;
         end
      end
   end

endmodule

// File: tb/tb_riscv_decode.sv
// Directed-vector bench for riscv_decode; expected values hand-derived from the encodings.
module tb_riscv_decode;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_dec_valid_i;
   logic [31:0] if_dec_instr_i;
   logic        wb_rf_we_i;
   logic [4:0]  wb_rd_addr_i;
   logic [31:0] wb_rd_data_i;
   logic        dec_ex_valid_o;
   logic [31:0] dec_ex_rs1_data_o;
   logic [31:0] dec_ex_rs2_data_o;
   logic [31:0] dec_ex_imm_o;
   logic [4:0]  dec_ex_rd_addr_o;
   logic [2:0]  dec_ex_funct3_o;
   logic [3:0]  dec_ex_alu_op_o;
   logic [8:0]  dec_ex_ctrl_o;
   logic        dec_ex_illegal_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   riscv_decode dut (
      .clk               (clk),
      .reset             (reset),
      .if_dec_valid_i    (if_dec_valid_i),
      .if_dec_instr_i    (if_dec_instr_i),
      .wb_rf_we_i        (wb_rf_we_i),
      .wb_rd_addr_i      (wb_rd_addr_i),
      .wb_rd_data_i      (wb_rd_data_i),
      .dec_ex_valid_o    (dec_ex_valid_o),
      .dec_ex_rs1_data_o (dec_ex_rs1_data_o),
      .dec_ex_rs2_data_o (dec_ex_rs2_data_o),
      .dec_ex_imm_o      (dec_ex_imm_o),
      .dec_ex_rd_addr_o  (dec_ex_rd_addr_o),
      .dec_ex_funct3_o   (dec_ex_funct3_o),
      .dec_ex_alu_op_o   (dec_ex_alu_op_o),
      .dec_ex_ctrl_o     (dec_ex_ctrl_o),
      .dec_ex_illegal_o  (dec_ex_illegal_o)
   );

   task automatic check(
      input string       tag,
      input logic [31:0] obs,
      input logic [31:0] exp
   );
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", tag, obs, exp);
      end
   endtask

   // Drive one instruction for one cycle; returns at the negedge after capture.
   task automatic issue(input logic [31:0] ins);
      if_dec_valid_i = 1'b1;
      if_dec_instr_i = ins;
      @(negedge clk);
      if_dec_valid_i = 1'b0;
   endtask

   task automatic wb(input logic [4:0] a, input logic [31:0] d);
      wb_rf_we_i   = 1'b1;
      wb_rd_addr_i = a;
      wb_rd_data_i = d;
      @(negedge clk);
      wb_rf_we_i = 1'b0;
   endtask

   logic [31:0] bypass_exp;

   initial begin
`ifdef RISCV_RF_BYPASS_EN
      bypass_exp = 32'h0000_00AA;
`else
      bypass_exp = 32'h0000_0000;
`endif
      reset          = 1'b0;
      if_dec_valid_i = 1'b0;
      if_dec_instr_i = '0;
      wb_rf_we_i     = 1'b0;
      wb_rd_addr_i   = '0;
      wb_rd_data_i   = '0;
      #1;
      check("rst_valid", 32'(dec_ex_valid_o), 32'h0);
      check("rst_imm", dec_ex_imm_o, 32'h0);
      check("rst_ctrl", 32'(dec_ex_ctrl_o), 32'h0);
      check("rst_rd", 32'(dec_ex_rd_addr_o), 32'h0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // addi x5,x0,-3
      issue(32'hFFD0_0293);
      check("addi_valid", 32'(dec_ex_valid_o), 32'h1);
      check("addi_imm", dec_ex_imm_o, 32'hFFFF_FFFD);
      check("addi_rd", 32'(dec_ex_rd_addr_o), 32'd5);
      check("addi_alu", 32'(dec_ex_alu_op_o), 32'h0);
      check("addi_ctrl", 32'(dec_ex_ctrl_o), 32'h180);
      check("addi_ill", 32'(dec_ex_illegal_o), 32'h0);
      @(negedge clk);
      check("addi_pulse_end", 32'(dec_ex_valid_o), 32'h0);
      check("addi_imm_hold", dec_ex_imm_o, 32'hFFFF_FFFD);

      // add x8,x7,x7 after write-back of x7
      wb(5'd7, 32'h0000_1234);
      @(negedge clk);
      issue(32'h0073_8433);
      check("add_rs1", dec_ex_rs1_data_o, 32'h0000_1234);
      check("add_rs2", dec_ex_rs2_data_o, 32'h0000_1234);
      check("add_alu", 32'(dec_ex_alu_op_o), 32'h0);
      check("add_rd", 32'(dec_ex_rd_addr_o), 32'd8);
      check("add_ctrl", 32'(dec_ex_ctrl_o), 32'h100);

      // write to x0 is discarded; add x8,x0,x0
      wb(5'd0, 32'hDEAD_BEEF);
      @(negedge clk);
      issue(32'h0000_0433);
      check("x0_rs1", dec_ex_rs1_data_o, 32'h0);
      check("x0_rs2", dec_ex_rs2_data_o, 32'h0);

      // sw x9,4(x0) in the same cycle as write-back of x9
      wb_rf_we_i   = 1'b1;
      wb_rd_addr_i = 5'd9;
      wb_rd_data_i = 32'h0000_00AA;
      issue(32'h0090_2223);
      wb_rf_we_i = 1'b0;
      check("sw_byp_rs2", dec_ex_rs2_data_o, bypass_exp);
      check("sw_imm", dec_ex_imm_o, 32'h4);
      check("sw_f3", 32'(dec_ex_funct3_o), 32'h2);
      check("sw_store", 32'(dec_ex_ctrl_o[5]), 32'h1);
      check("sw_rfwe", 32'(dec_ex_ctrl_o[8]), 32'h0);
      issue(32'h0090_2223);
      check("sw_late_rs2", dec_ex_rs2_data_o, 32'h0000_00AA);

      // beq x1,x2,-8
      issue(32'hFE20_8CE3);
      check("beq_imm", dec_ex_imm_o, 32'hFFFF_FFF8);
      check("beq_ctrl", 32'(dec_ex_ctrl_o), 32'h010);
      check("beq_f3", 32'(dec_ex_funct3_o), 32'h0);
      check("beq_alu", 32'(dec_ex_alu_op_o), 32'h8);

      // jal x1,+2048
      issue(32'h0010_00EF);
      check("jal_imm", dec_ex_imm_o, 32'h0000_0800);
      check("jal_is_jal", 32'(dec_ex_ctrl_o[3]), 32'h1);
      check("jal_rfwe", 32'(dec_ex_ctrl_o[8]), 32'h1);
      check("jal_rd", 32'(dec_ex_rd_addr_o), 32'd1);

      // back-to-back: lui x10,0x12345 then auipc x11,1
      if_dec_valid_i = 1'b1;
      if_dec_instr_i = 32'h1234_5537;
      @(negedge clk);
      check("lui_valid", 32'(dec_ex_valid_o), 32'h1);
      check("lui_imm", dec_ex_imm_o, 32'h1234_5000);
      check("lui_rd", 32'(dec_ex_rd_addr_o), 32'd10);
      check("lui_is_lui", 32'(dec_ex_ctrl_o[1]), 32'h1);
      if_dec_instr_i = 32'h0000_1597;
      @(negedge clk);
      if_dec_valid_i = 1'b0;
      check("auipc_valid", 32'(dec_ex_valid_o), 32'h1);
      check("auipc_imm", dec_ex_imm_o, 32'h0000_1000);
      check("auipc_rd", 32'(dec_ex_rd_addr_o), 32'd11);
      check("auipc_is", 32'(dec_ex_ctrl_o[0]), 32'h1);
      @(negedge clk);
      check("b2b_end", 32'(dec_ex_valid_o), 32'h0);

      // illegal opcode
      issue(32'h0000_007F);
      check("ill_op_valid", 32'(dec_ex_valid_o), 32'h1);
      check("ill_op_ill", 32'(dec_ex_illegal_o), 32'h1);
      check("ill_op_ctrl", 32'(dec_ex_ctrl_o), 32'h0);
      check("ill_op_alu", 32'(dec_ex_alu_op_o), 32'h0);
      @(negedge clk);
      check("ill_op_end", 32'(dec_ex_valid_o), 32'h0);

      // OP with funct7 = 0000001
      issue(32'h0273_8433);
      check("ill_f7_valid", 32'(dec_ex_valid_o), 32'h1);
      check("ill_f7_ill", 32'(dec_ex_illegal_o), 32'h1);
      check("ill_f7_ctrl", 32'(dec_ex_ctrl_o), 32'h0);
      check("ill_f7_alu", 32'(dec_ex_alu_op_o), 32'h0);
      @(negedge clk);
      check("ill_f7_end", 32'(dec_ex_valid_o), 32'h0);

      // reset asserted mid-pulse
      issue(32'hFFD0_0293);
      check("pre_rst_valid", 32'(dec_ex_valid_o), 32'h1);
      #2 reset = 1'b0;
      #1;
      check("mid_rst_valid", 32'(dec_ex_valid_o), 32'h0);
      check("mid_rst_imm", dec_ex_imm_o, 32'h0);
      check("mid_rst_ctrl", 32'(dec_ex_ctrl_o), 32'h0);
      check("mid_rst_rd", 32'(dec_ex_rd_addr_o), 32'h0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      issue(32'h0073_8433);
      check("post_valid", 32'(dec_ex_valid_o), 32'h1);
      check("post_rs1", dec_ex_rs1_data_o, 32'h0);
      check("post_rs2", dec_ex_rs2_data_o, 32'h0);
      check("post_rd", 32'(dec_ex_rd_addr_o), 32'd8);
      check("post_ctrl", 32'(dec_ex_ctrl_o), 32'h100);
      issue(32'h0090_2223);
      check("post_x9", dec_ex_rs2_data_o, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got running want finished");
      $fatal(1);
   end

endmodule
